regfile_wb_sched: RTL and testbench

//  Writeback scheduler and scoreboard for the 32x32 register file write port.
//  - Two producers share the register file's single write port: ALU result and LSU load data.
//  - Arbitration is round-robin; requests to x0 are suppressed.
//  - Keeps per-register busy bits so decode can stall on RAW hazards.
//  - Sits between the execute/memory stages and the register-file top.

---
 rtl/rv_rf_pkg.sv | 15 +
 rtl/rr_arb2.sv | 31 +++
 rtl/regfile_wb_sched.sv | 87 ++++++++
 tb/tb_regfile_wb_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_rf_pkg.sv
// Shared definitions for the register-file writeback path: widths, requester
// identities and the hardwired-zero register address.
package rv_rf_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  // Doubles as the bit index of each requester in req/grant vectors.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  localparam logic [REG_AW-1:0] REG_X0 = '0;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// remembered last winner; the winner is only remembered when accept is pulsed.
module rr_arb2
  import rv_rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  req_e last_grant;

  always_comb begin
    grant = '0;
    if (req[REQ_ALU] && (!req[REQ_LSU] || last_grant == REQ_LSU))
      grant[REQ_ALU] = 1'b1;
    else if (req[REQ_LSU])
      grant[REQ_LSU] = 1'b1;
  end

  // Starting as LSU lets the ALU win the first conflict after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= REQ_LSU;
    else if (accept)
      last_grant <= grant[REQ_LSU] ? REQ_LSU : REQ_ALU;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the single register-file write port: arbitrates ALU
// and LSU results, registers the write, and tracks per-register busy bits.
module regfile_wb_sched
  import rv_rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              RegWrite,
  output logic [REG_AW-1:0] Rd,
  output logic [XLEN-1:0]   Write_data,
  input  logic [REG_AW-1:0] Rs1,
  input  logic [REG_AW-1:0] Rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              sb_err
);

  logic [1:0]        grant;
  logic              xfer_p0;
  logic              wr_en_p0;
  logic [REG_AW-1:0] sel_rd_p0;
  logic [XLEN-1:0]   sel_data_p0;
  logic              waw_p0;
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({lsu_valid, alu_valid}),
    .accept (xfer_p0),
    .grant  (grant)
  );

  assign alu_ready   = grant[REQ_ALU];
  assign lsu_ready   = grant[REQ_LSU];
  assign xfer_p0     = alu_ready | lsu_ready;
  assign sel_rd_p0   = lsu_ready ? lsu_rd   : alu_rd;
  assign sel_data_p0 = lsu_ready ? lsu_data : alu_data;
  // x0 writes are handshaken away but never reach the register file.
  assign wr_en_p0    = xfer_p0 && (sel_rd_p0 != REG_X0);
  assign waw_p0      = issue_valid && (issue_rd != REG_X0) && busy[issue_rd];

  // Retire clears first so a same-edge issue to that rd re-arms the bit.
  always_comb begin
    busy_nxt = busy;
    if (xfer_p0)
      busy_nxt[sel_rd_p0] = 1'b0;
    if (issue_valid)
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[REG_X0] = 1'b0;
  end

  // ---- p0 -> p1: registered write port and scoreboard ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      Rd         <= '0;
      Write_data <= '0;
      busy       <= '0;
      sb_err     <= 1'b0;
    end else begin
      RegWrite <= wr_en_p0;
      if (wr_en_p0) begin
        Rd         <= sel_rd_p0;
        Write_data <= sel_data_p0;
      end
      busy <= busy_nxt;
      if (waw_p0)
        sb_err <= 1'b1;
    end
  end

  assign rs1_busy = (Rs1 != REG_X0) && busy[Rs1];
  assign rs2_busy = (Rs2 != REG_X0) && busy[Rs2];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed and randomized bench for regfile_wb_sched against a behavioural
// model of the arbitration, write port and scoreboard.
module tb_regfile_wb_sched;
  import rv_rf_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              alu_valid, lsu_valid;
  logic              alu_ready, lsu_ready;
  logic [REG_AW-1:0] alu_rd, lsu_rd;
  logic [XLEN-1:0]   alu_data, lsu_data;
  logic              RegWrite;
  logic [REG_AW-1:0] Rd;
  logic [XLEN-1:0]   Write_data;
  logic [REG_AW-1:0] Rs1, Rs2;
  logic              rs1_busy, rs2_busy, sb_err;

  int errors = 0;
  int checks = 0;

  // Model state
  bit              m_busy [NREGS];
  bit              m_last_lsu;
  bit              m_we;
  bit [REG_AW-1:0] m_rd;
  bit [XLEN-1:0]   m_data;
  bit              m_err;
  bit              acc_alu, acc_lsu;

  regfile_wb_sched dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data),
    .Rs1(Rs1), .Rs2(Rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    m_last_lsu = 1'b1;
    m_we = 1'b0; m_rd = '0; m_data = '0; m_err = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(m_we));
    chk({tag, ".Rd"}, 32'(Rd), 32'(m_rd));
    chk({tag, ".Write_data"}, Write_data, m_data);
    chk({tag, ".sb_err"}, 32'(sb_err), 32'(m_err));
    chk({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(Rs1 != 0 && m_busy[Rs1]));
    chk({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(Rs2 != 0 && m_busy[Rs2]));
  endtask

  // One clock: check the handshake against the model, advance the model, then
  // check the registered outputs and scoreboard after the edge.
  task automatic tick(input string tag);
    bit              ag, lg, xf;
    bit [REG_AW-1:0] rd;
    bit [XLEN-1:0]   d;
    bit              old_busy_issue;
    #1;
    ag = alu_valid && (!lsu_valid || m_last_lsu);
    lg = lsu_valid && !ag;
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(ag));
    chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(lg));
    xf = ag || lg;
    rd = lg ? lsu_rd : alu_rd;
    d  = lg ? lsu_data : alu_data;
    old_busy_issue = m_busy[issue_rd];
    m_we = xf && (rd != 0);
    if (m_we) begin m_rd = rd; m_data = d; end
    if (xf) begin m_busy[rd] = 1'b0; m_last_lsu = lg; end
    if (issue_valid && issue_rd != 0) begin
      if (old_busy_issue) m_err = 1'b1;
      m_busy[issue_rd] = 1'b1;
    end
    acc_alu = ag; acc_lsu = lg;
    @(posedge clk); #1;
    chk_outputs(tag);
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    Rs1 = 0; Rs2 = 0;
  endtask

  initial begin
    bit [3:0] pat;
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    // Reset state
    Rs1 = 5; Rs2 = 31;
    #1 chk_outputs("reset");
    @(posedge clk); #1;
    tick("idle");

    // Single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick("alu5");
    alu_valid = 0;
    chk("alu5.direct_we", 32'(RegWrite), 32'd1);
    chk("alu5.direct_rd", 32'(Rd), 32'd5);
    chk("alu5.direct_data", Write_data, 32'hDEADBEEF);
    tick("alu5.after");

    // LSU alone, so the next conflict favours ALU
    lsu_valid = 1; lsu_rd = 1; lsu_data = 32'h1111_0001;
    tick("lsu1");
    lsu_valid = 0;

    // Both requesting for four transfers with fresh payloads
    alu_valid = 1; lsu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom;
      lsu_rd = 5'($urandom_range(1, 31)); lsu_data = $urandom;
      tick("rr");
      pat[i] = acc_alu;
      chk("rr.we", 32'(RegWrite), 32'd1);
    end
    chk("rr.pattern", 32'(pat), 32'b0101);
    alu_valid = 0; lsu_valid = 0;

    // RAW tracking on x7
    issue_valid = 1; issue_rd = 7;
    tick("issue7");
    issue_valid = 0; Rs1 = 7;
    #1 chk("raw7.busy", 32'(rs1_busy), 32'd1);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_0777;
    tick("retire7");
    lsu_valid = 0;
    chk("raw7.clear", 32'(rs1_busy), 32'd0);

    // Same-edge issue and retire of x9: set wins
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    issue_valid = 1; issue_rd = 9; Rs2 = 9;
    tick("same9");
    alu_valid = 0; issue_valid = 0;
    chk("same9.busy", 32'(rs2_busy), 32'd1);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9;
    tick("retire9");
    lsu_valid = 0;

    // x0 request is accepted but never written
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
    #1 chk("x0.ready", 32'(alu_ready), 32'd1);
    tick("x0");
    alu_valid = 0;
    chk("x0.we", 32'(RegWrite), 32'd0);
    Rs1 = 0;
    #1 chk("x0.rs1_busy", 32'(rs1_busy), 32'd0);

    // Random traffic; producers hold payload until accepted
    for (int i = 0; i < 300; i++) begin
      if (!alu_valid || acc_alu) begin
        alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
      end
      if (!lsu_valid || acc_lsu) begin
        lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd = 5'($urandom);
      Rs1 = 5'($urandom); Rs2 = 5'($urandom);
      tick("rand");
    end
    idle_inputs();

    // Reset everything, then a WAW on x3
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    issue_valid = 1; issue_rd = 3;
    tick("waw3.a");
    tick("waw3.b");
    issue_valid = 0;
    chk("waw3.err", 32'(sb_err), 32'd1);
    tick("waw3.hold");

    // Reset asserted while a write is on the port and another is requested
    alu_valid = 1; alu_rd = 4; alu_data = 32'hCAFE_F00D;
    issue_valid = 1; issue_rd = 4;
    tick("pre_rst");
    chk("pre_rst.we", 32'(RegWrite), 32'd1);
    issue_valid = 0; Rs1 = 3; Rs2 = 4;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_outputs("midrst");
    alu_valid = 0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    tick("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
